// File: rtl/hexdump_pkg.sv
// Shared constants, emitter state encoding and nibble-to-ASCII helper for
// the hexdump formatter. The OFS state only exists when HEXDUMP_OFFSET_EN
// is defined.
package hexdump_pkg;

  localparam logic [7:0] ASCII_SP    = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
`ifdef HEXDUMP_OFFSET_EN
    ST_OFS  = 3'd1,
`endif
    ST_HI   = 3'd2,
    ST_LO   = 3'd3,
    ST_SEP  = 3'd4,
    ST_CR   = 3'd5,
    ST_LF   = 3'd6
  } state_e;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hexdigit(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/hexdump_byte_fifo.sv
// Circular byte buffer between the UART receiver and the hexdump emitter.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A byte arriving while full is dropped and reported one cycle later.
module hexdump_byte_fifo
  import hexdump_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic        full, push, pop;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  // Fullness is judged before any same-cycle pop, so a pop never rescues a
  // byte that arrives while full.
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow = overflow_q;

  // Next pointer values and the drop indication.
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    overflow_d = wr_en && full;
  end

  // Pointer and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/hexdump_fmt.sv
// Streaming hexdump formatter: buffered bytes become "XX " pairs, lines of
// BYTES_PER_LINE bytes end with CR LF, and flush closes a partial line.
// Define HEXDUMP_OFFSET_EN to prefix every line with an 8-digit byte offset
// followed by ": ".
//
// state | meaning
// IDLE  | wait for a buffered byte, pop it into the hold register
// OFS   | print line offset: 8 hex digits, ':' and ' '
// HI    | print high nibble of held byte
// LO    | print low nibble, advance column and offset
// SEP   | print ' ' between bytes
// CR    | print carriage return
// LF    | print line feed, start a new line
module hexdump_fmt
  import hexdump_pkg::*;
#(
  parameter int BYTES_PER_LINE = 16,
  parameter int IN_DEPTH       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_strobe,
  input  logic       flush,
  output logic       overflow,
  output logic [7:0] out_data,
  output logic       out_strobe,
  input  logic       out_ready
);

  localparam logic [7:0] BPL = 8'(BYTES_PER_LINE);

  logic [7:0]  fifo_rd_data;
  logic        fifo_empty;
  logic        fifo_pop;

  state_e      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  col_q, col_d;
  logic [31:0] offset_q, offset_d;
  logic        flush_pend_q, flush_pend_d;
  logic        out_strobe_q, out_strobe_d;
  logic [7:0]  out_data_q, out_data_d;
  logic [7:0]  col_inc;
  logic        emit;

`ifdef HEXDUMP_OFFSET_EN
  logic [3:0]  ofs_idx_q, ofs_idx_d;
  logic [3:0]  ofs_nib;
  logic [7:0]  ofs_char;
`endif

  hexdump_byte_fifo #(
    .DEPTH(IN_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_data  (in_data),
    .wr_en    (in_strobe),
    .rd_en    (fifo_pop),
    .rd_data  (fifo_rd_data),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  assign out_strobe = out_strobe_q;
  assign out_data   = out_data_q;
  assign col_inc    = col_q + 8'd1;
  // The gap after every strobe gives the transmitter a cycle to drop ready.
  assign emit       = (state_q != ST_IDLE) && out_ready && !out_strobe_q;

`ifdef HEXDUMP_OFFSET_EN
  // Character of the offset column selected by ofs_idx (digits MSB first).
  always_comb begin
    ofs_nib = offset_q[{~ofs_idx_q[2:0], 2'b00} +: 4];
    if (ofs_idx_q < 4'd8) begin
      ofs_char = hexdigit(ofs_nib);
    end else if (ofs_idx_q == 4'd8) begin
      ofs_char = ASCII_COLON;
    end else begin
      ofs_char = ASCII_SP;
    end
  end
`endif

  // Emitter next-state, counters and output character.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    col_d        = col_q;
    offset_d     = offset_q;
    flush_pend_d = flush_pend_q;
    out_strobe_d = 1'b0;
    out_data_d   = out_data_q;
    fifo_pop     = 1'b0;
`ifdef HEXDUMP_OFFSET_EN
    ofs_idx_d    = ofs_idx_q;
`endif

    // A flush at a clean line boundary has nothing to close.
    if (flush && ((col_q != 8'd0) || !((state_q == ST_IDLE) || (state_q == ST_SEP)))) begin
      flush_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // Hold off popping while the transmitter is stalled, so the buffer
        // depth alone bounds how many bytes can be absorbed.
        if (!fifo_empty && out_ready) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_rd_data;
`ifdef HEXDUMP_OFFSET_EN
          ofs_idx_d = 4'd0;
          state_d   = (col_q == 8'd0) ? ST_OFS : ST_HI;
`else
          state_d   = ST_HI;
`endif
        end
      end
`ifdef HEXDUMP_OFFSET_EN
      ST_OFS: begin
        if (emit) begin
          out_strobe_d = 1'b1;
          out_data_d   = ofs_char;
          if (ofs_idx_q == 4'd9) begin
            state_d = ST_HI;
          end else begin
            ofs_idx_d = ofs_idx_q + 4'd1;
          end
        end
      end
`endif
      ST_HI: begin
        if (emit) begin
          out_strobe_d = 1'b1;
          out_data_d   = hexdigit(hold_q[7:4]);
          state_d      = ST_LO;
        end
      end
      ST_LO: begin
        if (emit) begin
          out_strobe_d = 1'b1;
          out_data_d   = hexdigit(hold_q[3:0]);
          col_d        = col_inc;
          offset_d     = offset_q + 32'd1;
          if ((col_inc == BPL) || flush_pend_q) begin
            state_d = ST_CR;
          end else begin
            state_d = ST_SEP;
          end
        end
      end
      ST_SEP: begin
        if (emit) begin
          out_strobe_d = 1'b1;
          out_data_d   = ASCII_SP;
          state_d      = flush_pend_q ? ST_CR : ST_IDLE;
        end
      end
      ST_CR: begin
        if (emit) begin
          out_strobe_d = 1'b1;
          out_data_d   = ASCII_CR;
          state_d      = ST_LF;
        end
      end
      ST_LF: begin
        if (emit) begin
          out_strobe_d = 1'b1;
          out_data_d   = ASCII_LF;
          col_d        = 8'd0;
          flush_pend_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Emitter registers; reset abandons any partially printed line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      col_q        <= '0;
      offset_q     <= '0;
      flush_pend_q <= 1'b0;
      out_strobe_q <= 1'b0;
      out_data_q   <= '0;
`ifdef HEXDUMP_OFFSET_EN
      ofs_idx_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      col_q        <= col_d;
      offset_q     <= offset_d;
      flush_pend_q <= flush_pend_d;
      out_strobe_q <= out_strobe_d;
      out_data_q   <= out_data_d;
`ifdef HEXDUMP_OFFSET_EN
      ofs_idx_q    <= ofs_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_hexdump_fmt.sv
// Self-checking bench for hexdump_fmt (4 bytes per line, 4-deep buffer).
// Expected character streams come from a byte-level model of the line format.
module tb_hexdump_fmt;

  localparam int BPL   = 4;
  localparam int DEPTH = 4;
`ifdef HEXDUMP_OFFSET_EN
  localparam bit OFS_EN = 1'b1;
  localparam int PRE    = 10;
`else
  localparam bit OFS_EN = 1'b0;
  localparam int PRE    = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_strobe = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       overflow;
  logic [7:0] out_data;
  logic       out_strobe;

  always #5 clk = ~clk;

  hexdump_fmt #(
    .BYTES_PER_LINE(BPL),
    .IN_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_data(in_data),
    .in_strobe(in_strobe),
    .flush(flush),
    .overflow(overflow),
    .out_data(out_data),
    .out_strobe(out_strobe),
    .out_ready(out_ready)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit tog_en = 1'b0;
  int tog_cnt = 0;
  int ovf_cnt = 0;
  logic prev_strobe = 1'b0;
  logic prev_ready = 1'b0;
  byte unsigned got[$];
  int st_cyc[$];
  byte unsigned exp_q[$];
  int m_col = 0;
  logic [31:0] m_ofs = 32'd0;
  string HEXS = "0123456789ABCDEF";

  typedef struct {
    logic [7:0]   data;
    byte unsigned hi;
    byte unsigned lo;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic string show(input byte unsigned q[$]);
    string s = "";
    for (int i = 0; i < q.size() && s.len() < 180; i++) begin
      if (q[i] == 8'h0D) s = {s, "\\r"};
      else if (q[i] == 8'h0A) s = {s, "\\n"};
      else s = {s, $sformatf("%c", q[i])};
    end
    return s;
  endfunction

  task automatic chk_stream(input string name);
    bit ok;
    ok = (got.size() == exp_q.size());
    if (ok) begin
      foreach (got[i]) if (got[i] != exp_q[i]) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, show(got), show(exp_q));
    end
  endtask

  // Line-format model: what one consumed byte adds to the output stream.
  task automatic model_byte(input logic [7:0] b);
    if (OFS_EN && m_col == 0) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(HEXS[int'((m_ofs >> (4 * i)) & 32'hF)]);
      exp_q.push_back(8'h3A);
      exp_q.push_back(8'h20);
    end
    exp_q.push_back(HEXS[int'(b) / 16]);
    exp_q.push_back(HEXS[int'(b) % 16]);
    m_col++;
    m_ofs++;
    if (m_col == BPL) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      m_col = 0;
    end else begin
      exp_q.push_back(8'h20);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (tog_en) begin
      tog_cnt++;
      if (tog_cnt == 3) begin
        tog_cnt = 0;
        out_ready = ~out_ready;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data = b;
    in_strobe = 1'b1;
    tick();
    in_strobe = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_col = 0;
    m_ofs = 32'd0;
    got.delete();
    st_cyc.delete();
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 16 && n < 3000) begin
      tick();
      n++;
      if (out_strobe) quiet = 0;
      else quiet++;
    end
    if (quiet < 16) begin
      checks++;
      errors++;
      $display("FAIL %s: output never went quiet within 3000 cycles", name);
    end
  endtask

  task automatic wait_char(input byte unsigned c, input string name);
    int n = 0;
    while (!(out_strobe && out_data == c) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL %s: character %c not seen within 400 cycles", name, c);
    end
  endtask

  // Output capture plus protocol checks. A strobe seen here was launched at
  // the edge closing the previous cycle, so that cycle's ready must be 1.
  always @(negedge clk) begin
    if (!reset && out_strobe) begin
      got.push_back(out_data);
      st_cyc.push_back(cyc);
      chk("strobe_back_to_back", prev_strobe, 0);
      chk("strobe_without_ready", prev_ready, 1);
    end
    if (!reset && overflow) ovf_cnt++;
    prev_strobe = out_strobe;
    prev_ready  = out_ready;
  end

  initial begin
    int bad;
    logic [7:0] b;
    logic [7:0] ovf_bytes[6];

    vecs[0] = '{8'h00, "0", "0"};
    vecs[1] = '{8'h09, "0", "9"};
    vecs[2] = '{8'h3A, "3", "A"};
    vecs[3] = '{8'h9F, "9", "F"};
    vecs[4] = '{8'hC6, "C", "6"};
    vecs[5] = '{8'hFF, "F", "F"};
    vecs[6] = '{8'h5E, "5", "E"};

    // Reset values while reset is held.
    reset = 1'b1;
    tick(); tick(); tick();
    chk("reset_out_strobe", out_strobe, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_overflow", overflow, 0);
    reset = 1'b0;

    // One full line, with first-strobe latency and sustained spacing.
    out_ready = 1'b1;
    do_reset();
    model_byte(8'h00); model_byte(8'h1F); model_byte(8'hA5); model_byte(8'hFF);
    in_data = 8'h00; in_strobe = 1'b1;
    tick();
    chk("latency_T", out_strobe, 0);
    in_data = 8'h1F;
    tick();
    chk("latency_T1", out_strobe, 0);
    in_data = 8'hA5;
    tick();
    chk("latency_T2_strobe", out_strobe, 1);
    chk("latency_T2_data", out_data, 8'h30);
    in_data = 8'hFF;
    tick();
    in_strobe = 1'b0;
    drain("line_4B");
    chk_stream("line_4B");
    chk("line_4B_count", got.size(), OFS_EN ? 23 : 13);
    bad = 0;
    for (int i = 1; i < st_cyc.size(); i++) if (st_cyc[i] - st_cyc[i-1] != 2) bad++;
    chk("line_4B_spacing", bad, 0);

    // Five bytes: one full line and a trailing partial line.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      model_byte(8'h10 + 8'(i));
      send_byte(8'h10 + 8'(i));
    end
    drain("five_bytes");
    chk_stream("five_bytes");
    repeat (30) tick();
    chk("five_bytes_no_extra", got.size(), exp_q.size());

    // Table of single bytes: hex digit rendering.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      send_byte(vecs[v].data);
      drain("table");
      chk($sformatf("table%0d_hi", v), (got.size() > PRE) ? got[PRE] : -1, vecs[v].hi);
      chk($sformatf("table%0d_lo", v), (got.size() > PRE + 1) ? got[PRE+1] : -1, vecs[v].lo);
      chk($sformatf("table%0d_len", v), got.size(), PRE + 3);
    end

    // Flush while the separator is pending, then a flush at a line boundary.
    do_reset();
    model_byte(8'hAB);
    send_byte(8'hAB);
    wait_char("B", "flush_wait_B");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    m_col = 0;
    drain("flush_in_sep");
    chk_stream("flush_in_sep");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (20) tick();
    chk("flush_idle_silent", got.size(), exp_q.size());
    model_byte(8'h5A);
    send_byte(8'h5A);
    drain("after_flush");
    chk_stream("after_flush");

    // Overflow with the transmitter stalled.
    out_ready = 1'b0;
    do_reset();
    ovf_cnt = 0;
    ovf_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hEE, 8'hDD};
    for (int k = 0; k < 6; k++) begin
      in_data = ovf_bytes[k];
      in_strobe = 1'b1;
      tick();
      chk($sformatf("overflow_byte%0d", k + 1), overflow, (k >= 4) ? 1 : 0);
      if (k < 4) model_byte(ovf_bytes[k]);
    end
    in_strobe = 1'b0;
    tick(); tick();
    chk("overflow_pulses", ovf_cnt, 2);
    chk("stalled_no_output", got.size(), 0);
    out_ready = 1'b1;
    drain("overflow_kept");
    chk_stream("overflow_kept");

    // Random bursts with ready toggling every 3 cycles.
    do_reset();
    ovf_cnt = 0;
    tog_cnt = 0;
    tog_en = 1'b1;
    for (int burst = 0; burst < 12; burst++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int j = 0; j < nb; j++) begin
        b = 8'($urandom);
        model_byte(b);
        send_byte(b);
        repeat ($urandom_range(0, 2)) tick();
      end
      drain("rand");
      chk_stream($sformatf("rand_burst%0d", burst));
      got.delete();
      exp_q.delete();
    end
    chk("rand_no_overflow", ovf_cnt, 0);
    tog_en = 1'b0;
    out_ready = 1'b1;

    // Reset in the middle of a line.
    do_reset();
    send_byte(8'h3C);
    send_byte(8'h11);
    wait_char("C", "reset_wait_C");
    reset = 1'b1;
    tick();
    chk("midreset_strobe0", out_strobe, 0);
    tick();
    chk("midreset_strobe1", out_strobe, 0);
    reset = 1'b0;
    m_col = 0;
    m_ofs = 32'd0;
    got.delete();
    exp_q.delete();
    repeat (20) tick();
    chk("midreset_buffer_empty", got.size(), 0);
    model_byte(8'h07);
    send_byte(8'h07);
    drain("after_reset");
    chk_stream("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hexdump_fmt.md
# hexdump_fmt

Streaming hexdump formatter that sits between `uart_rx` and `uart_tx`. It replaces the fixed two-character-per-byte path: received bytes are buffered, rendered as uppercase ASCII hex pairs separated by spaces, and broken into lines of `BYTES_PER_LINE` bytes terminated by CR LF. A flush input closes a partial line. An optional offset column prefixes every line.

## Interface

Parameters:
- `BYTES_PER_LINE`, 16: bytes per output line, range 1..255.
- `IN_DEPTH`, 16: input byte buffer depth. Power of two, ≥2.

Ports:
- `clk` in 1: single clock for the block; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `in_data` in 8: received byte.
- `in_strobe` in 1: one-cycle pulse; `in_data` is valid in that cycle.
- `flush` in 1: one-cycle pulse requesting termination of a partial line.
- `overflow` out 1: one-cycle pulse when a byte is dropped because the buffer is full.
- `out_data` out 8: ASCII character to transmit; stable from the strobe until the next strobe.
- `out_strobe` out 1: one-cycle pulse that hands `out_data` to the transmitter.
- `out_ready` in 1: the transmitter can accept a character.

## Operation

- Input buffer: circular register array of `IN_DEPTH` bytes with `log2(IN_DEPTH)+1`-bit read and write pointers.
  - Full when the pointers' MSBs differ and the rest are equal. Empty when the pointers are equal.
  - When `in_strobe` arrives with the buffer full, the byte is dropped and `overflow` pulses. A pop in the same cycle does not free the slot for that byte.
  - A push and a pop in the same cycle, with the buffer not full, are both performed.
- Emitter state machine. States: IDLE, OFS, HI, LO, SEP, CR, LF.
  - IDLE: when the buffer is non-empty, pop a byte into the hold register. If `col==0` and the offset column is enabled, go to OFS; otherwise go to HI.
  - OFS: emit 8 hex digits of `offset`, MSB first, then ':' and then ' '. This is 10 characters; `ofs_idx` counts 0..9. Then go to HI.
  - HI: emit hexdigit(byte[7:4]). Then go to LO.
  - LO: emit hexdigit(byte[3:0]), then increment `col` and `offset`.
    - If `col` reaches `BYTES_PER_LINE`, go to CR.
    - Else if a flush is pending, go to CR.
    - Else go to SEP.
  - SEP: emit ' ' (0x20), then go to IDLE.
  - CR: emit 0x0D, then go to LF.
  - LF: emit 0x0A. Clear `col` and the flush-pending flag. Go to IDLE.
- Flush:
  - A `flush` pulse sets flush-pending only if `col!=0`, or if the state is not IDLE or SEP.
  - If flush is pending in SEP, the SEP character is still emitted. The machine then goes to CR instead of IDLE, skipping the wait for the next byte.
  - A flush with `col==0` in IDLE is ignored.
- Hex digits are '0'..'9' (0x30..0x39) and 'A'..'F' (0x41..0x46).
- `offset` is 32 bits, counts bytes consumed, and wraps from 0xFFFFFFFF to 0. The value printed is the offset of the line's first byte.

## Timing

- Reset values:
  - `out_strobe=0`, `out_data=0x00`, `overflow=0`.
  - State IDLE, both pointers 0, `col=0`, `offset=0`, flush-pending 0.
  - A reset in the middle of a line discards the remaining characters and all buffered bytes; no CR LF is emitted.
- Character emission: in every non-IDLE state, a character is emitted in the cycle where `out_ready=1` and `out_strobe=0`.
  - At most one strobe is issued per two cycles. This covers the transmitter's one-cycle ready deassert latency.
  - `out_data` is registered and changes only together with `out_strobe`.
- Latency: with the buffer empty, in IDLE and `out_ready=1`:
  - the byte is written at the edge ending the `in_strobe` cycle (T);
  - IDLE pops at T+1;
  - the first `out_strobe` is at T+2.
- Throughput: sustained output with `out_ready` always high is one character per 2 cycles.
- `overflow` is registered and occurs 1 cycle after the offending `in_strobe`.

## Configuration

- `HEXDUMP_OFFSET_EN` defined: the OFS state, `ofs_idx`, and offset printing are compiled in. Every line starts with `XXXXXXXX: `.
- Not defined: OFS is absent and lines start directly with hex digits. The `offset` counter is still kept (32 bits) so that it can be probed in simulation.

## Structure

- `hexdump_pkg` holds:
  - ASCII constants `ASCII_SP`, `ASCII_CR`, `ASCII_LF`, `ASCII_COLON`;
  - the state enum;
  - the `hexdigit(4-bit)` function.
- Sub-module `hexdump_byte_fifo` (parameter `DEPTH`) contains the buffer, its pointers, and the full/empty/overflow logic. The emitter FSM and counters stay in `hexdump_fmt`.

## Test plan

- `BYTES_PER_LINE=4`, offset off, `out_ready=1`. Send 0x00, 0x1F, 0xA5, 0xFF. Output must be "00 1F A5 FF\r\n": 13 strobes, each pair 2 cycles apart.
- Offset on, `BYTES_PER_LINE=2`. Send 5 bytes 0x10..0x14. Output must be "00000000: 10 11\r\n00000002: 12 13\r\n00000004: 14 ", with no further output until more input arrives.
- `BYTES_PER_LINE=16`. Send 0xAB, then pulse `flush` while in SEP. Output must be "AB \r\n" and `col` must return to 0. A second flush pulse in IDLE must produce nothing.
- `IN_DEPTH=4`, `out_ready=0`. Send 6 bytes. `overflow` must pulse exactly twice, for bytes 5 and 6. After raising `out_ready`, only bytes 1..4 are printed.
- `out_ready` toggling every 3 cycles. Check that `out_strobe` never occurs while `out_ready=0`, never occurs two cycles in a row, and that no character is lost or duplicated.
- Assert `reset` mid-line after "3C" is printed. `out_strobe` must stay 0 the next cycle and the buffer must be empty. A new byte 0x07 must print "07", with offset 00000000 if the offset column is enabled.
